ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
//  Per-frame ball position integrator for the pong game. On each frame strobe it looks up sin/cos of the
//  current heading (6-bit angle, 64 steps per turn) via the trig LUT and advances a fixed-point (x,y).
//  It reflects the heading at the top/bottom walls and on paddle-bounce requests, and flags left/right misses.
//  Sits between the frame timing/collision logic (upstream) and the ball renderer (downstream).
// PARAMETERS
//  H_RES      640  visible width, pixels
//  V_RES      480  visible height, pixels
//  BALL_SIZE  8    ball side, pixels; max legal x = H_RES-BALL_SIZE, max legal y = V_RES-BALL_SIZE
//  COORD_W    10   integer coordinate width
//  SPEED      2    pixels/frame at |sin|,|cos| = full scale (unsigned, 1..7)
// PORTS
//  CLK           in   1        system clock
//  RST           in   1        synchronous, active-high reset
//  frame_i       in   1        1-cycle strobe: start of vblank, request one motion step
//  serve_i       in   1        1-cycle strobe: recentre ball, load heading, start moving
//  theta_serve_i in   6        heading loaded on serve_i
//  bounce_x_i    in   1        1-cycle strobe from paddle collision: reflect horizontally
//  ball_x_o      out  COORD_W  integer x of ball top-left
//  ball_y_o      out  COORD_W  integer y of ball top-left (y grows downward)
//  theta_o       out  6        current heading
//  busy_o        out  1        high in LOOKUP/MOVE/CHECK
//  done_o        out  1        1-cycle strobe: step complete, outputs updated
//  miss_left_o   out  1        1-cycle strobe: ball crossed x<0
//  miss_right_o  out  1        1-cycle strobe: ball crossed x>H_RES-BALL_SIZE
// BEHAVIOUR
//  - Reset: state PARKED; x=XC=(H_RES-BALL_SIZE)/2, y=YC=(V_RES-BALL_SIZE)/2, fractions 0; theta_o=0;
//    bounce_pending=0; busy_o, done_o, miss_*_o = 0.
//  - Position regs: signed {int COORD_W+1, frac 7}; ball_*_o = integer part (clamped, never negative).
//  - Angle: sin(theta) positive for theta 1..31; dx = cos*SPEED, dy = sin*SPEED, signed 8b x unsigned 3b -> 11b
//    signed, LSB = 1/128 px, sign-extended before add. Trig: 0x7F=+127, 0x80=-128.
//  - FSM: PARKED -serve_i-> IDLE; IDLE -frame_i-> LOOKUP (register trig sin/cos of theta) -> MOVE
//    (x+=dx, y+=dy) -> CHECK -> IDLE. done_o asserted in CHECK: 3 cycles after the frame_i edge.
//  - frame_i outside IDLE is ignored (no queueing). busy_o high exactly in LOOKUP/MOVE/CHECK.
//  - CHECK, y: new y<0 -> y=0 (frac 0), theta=(64-theta)%64; y>V_RES-BALL_SIZE -> clamp, same reflection.
//  - CHECK, bounce: bounce_x_i latches bounce_pending in any state except PARKED; in CHECK, if pending,
//    theta=(32-theta)%64, pending cleared. Wall and bounce in same CHECK: both applied (theta+32)%64.
//  - CHECK, x: new x<0 -> miss_left_o pulse; x>H_RES-BALL_SIZE -> miss_right_o pulse; either: recentre,
//    fractions 0, pending cleared, theta unchanged, next state PARKED (done_o still pulses).
//    Miss takes precedence over bounce.
//  - serve_i: highest priority, any state, 1-cycle effect: x=XC, y=YC, fractions 0, theta=theta_serve_i,
//    pending cleared, state IDLE. An in-flight step is aborted: no done_o/miss pulse.
//    serve_i with frame_i same cycle: serve wins, frame dropped.
//  - RST mid-step: returns to reset state next edge, no strobes.
//  - PARKED: frame_i and bounce_x_i ignored; outputs hold centre position.
// STRUCTURE
//  - pong_defs.vh: FSM state encodings, THETA_HALF=6'd32, angle-reflection functions, FRAC_W=7.
//  - One sub-module: trig (theta_i=theta reg, sin_o/cos_o registered in LOOKUP).
//  - Remainder: FSM, two accumulators, clamp/compare, strobe regs.
// TESTING
//  1 serve theta=0 at defaults, 2 frames -> x_o 317 then 319, y_o 236 both, theta_o 0, done_o 3 cycles after each frame_i.
//  2 serve theta=48 (dy=-2.0 px, dx=0): frames 1..118 -> y_o 234..0; frame 119 -> y_o 0, theta_o 16, x_o 316.
//  3 serve theta=32 (dx=-2.0): frame 158 -> x_o 0; frame 159 -> miss_left_o pulse, x_o 316, PARKED; frame 160 ignored.
//  4 serve theta=0, bounce_x_i pulse in IDLE, frame -> theta_o 32; next frame x decreases.
//  5 frame_i repeated during LOOKUP/MOVE -> ignored, exactly one done_o; serve_i in MOVE -> x_o 316, no done_o.
//  6 RST asserted in CHECK -> next cycle PARKED, centre, theta_o 0, all strobes 0.

Source files
------------

// File: rtl/ball_motion_pkg.sv
// Shared constants, FSM state type and heading-reflection helpers for the
// pong ball integrator. Positions are signed fixed point: {int COORD_W+1, frac FRAC_W}.
package ball_motion_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int BALL_SIZE = 8;
  localparam int COORD_W   = 10;
  localparam int SPEED     = 2;
  localparam int FRAC_W    = 7;

  localparam int POS_W = COORD_W + 1 + FRAC_W;
  localparam int X_MAX = H_RES - BALL_SIZE;
  localparam int Y_MAX = V_RES - BALL_SIZE;
  localparam int XC    = X_MAX / 2;
  localparam int YC    = Y_MAX / 2;

  localparam logic [5:0] THETA_HALF = 6'd32;

  // Fixed-point versions of the centre and limits (fraction bits zero).
  localparam logic signed [POS_W-1:0] X_CENTRE = POS_W'(XC << FRAC_W);
  localparam logic signed [POS_W-1:0] Y_CENTRE = POS_W'(YC << FRAC_W);
  localparam logic signed [POS_W-1:0] Y_CLAMP  = POS_W'(Y_MAX << FRAC_W);
  // Integer part exceeds the max legal coordinate once the value reaches (MAX+1).0
  localparam logic signed [POS_W-1:0] X_LIMIT  = POS_W'((X_MAX + 1) << FRAC_W);
  localparam logic signed [POS_W-1:0] Y_LIMIT  = POS_W'((Y_MAX + 1) << FRAC_W);

  typedef enum logic [2:0] {
    ST_PARKED = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_MOVE   = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  // Top/bottom wall: negate the vertical component -> (64 - theta) % 64.
  function automatic logic [5:0] reflect_wall(input logic [5:0] t);
    return 6'd0 - t;
  endfunction

  // Paddle: negate the horizontal component -> (32 - theta) % 64.
  function automatic logic [5:0] reflect_paddle(input logic [5:0] t);
    return THETA_HALF - t;
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Control/status bundle between frame timing/collision logic (master) and
// the ball integrator (slave).
//   frame_i, serve_i, bounce_x_i : 1-cycle request strobes, no handshake;
//                                  a strobe is consumed in the cycle it is high
//                                  or dropped if the integrator cannot take it.
//   theta_serve_i                : heading loaded with serve_i.
//   ball_x_o/ball_y_o/theta_o    : current position/heading.
//   busy_o, done_o, miss_*_o     : status and 1-cycle completion strobes.
interface ball_motion_if;
  import ball_motion_pkg::*;

  logic               frame_i;
  logic               serve_i;
  logic [5:0]         theta_serve_i;
  logic               bounce_x_i;
  logic [COORD_W-1:0] ball_x_o;
  logic [COORD_W-1:0] ball_y_o;
  logic [5:0]         theta_o;
  logic               busy_o;
  logic               done_o;
  logic               miss_left_o;
  logic               miss_right_o;

  modport master (
    output frame_i, serve_i, theta_serve_i, bounce_x_i,
    input  ball_x_o, ball_y_o, theta_o, busy_o, done_o, miss_left_o, miss_right_o
  );

  modport slave (
    input  frame_i, serve_i, theta_serve_i, bounce_x_i,
    output ball_x_o, ball_y_o, theta_o, busy_o, done_o, miss_left_o, miss_right_o
  );

endinterface

// File: rtl/ball_motion_trig.sv
// Registered sine/cosine of a 6-bit heading (64 steps per turn).
// Values are round(128*sin) saturated to signed 8 bits: +1.0 -> 0x7F, -1.0 -> 0x80.
// Ports: clk, rst (sync, active high), load (capture new values),
//        theta_i (heading), sin_o/cos_o (signed 8-bit).
module ball_motion_trig (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [5:0]        theta_i,
  output logic signed [7:0] sin_o,
  output logic signed [7:0] cos_o
);

  // Quarter wave magnitude, k = 0..16 covers 0..90 degrees.
  function automatic logic [7:0] quarter(input logic [4:0] k);
    logic [7:0] m;
    case (k)
      5'd0:  m = 8'd0;
      5'd1:  m = 8'd13;
      5'd2:  m = 8'd25;
      5'd3:  m = 8'd37;
      5'd4:  m = 8'd49;
      5'd5:  m = 8'd60;
      5'd6:  m = 8'd71;
      5'd7:  m = 8'd81;
      5'd8:  m = 8'd91;
      5'd9:  m = 8'd99;
      5'd10: m = 8'd106;
      5'd11: m = 8'd113;
      5'd12: m = 8'd118;
      5'd13: m = 8'd122;
      5'd14: m = 8'd126;
      5'd15: m = 8'd127;
      5'd16: m = 8'd128;
      default: m = 8'd0;
    endcase
    return m;
  endfunction

  // Bit 5 selects the negative half-turn; bit 4 selects the mirrored quarter.
  function automatic logic signed [7:0] sin_lut(input logic [5:0] t);
    logic [4:0] k;
    logic [7:0] mag;
    k   = t[4] ? (5'd0 - t[4:0]) : t[4:0];
    mag = quarter(k);
    if (t[5]) return 8'd0 - mag;             // magnitude 128 becomes 0x80 = -128
    else      return (mag == 8'd128) ? 8'd127 : mag;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sin_o <= '0;
      cos_o <= '0;
    end else if (load) begin
      sin_o <= sin_lut(theta_i);
      cos_o <= sin_lut(theta_i + 6'd16);
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball position integrator.
// Ports: clk, rst (sync, active high), bus (ball_motion_if.slave),
//        dbg_state (current FSM state for observation).
// A frame step runs IDLE -> LOOKUP -> MOVE -> CHECK -> IDLE. The CHECK edge
// applies wall/paddle/miss corrections and registers done/miss strobes, so
// the strobes appear together with the corrected outputs, 3 edges after the
// edge that accepted frame_i.
module ball_motion
  import ball_motion_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ball_motion_if.slave bus,
  output state_t       dbg_state
);

  state_t                   state, state_nxt;
  logic signed [POS_W-1:0]  x_pos, y_pos, x_nxt, y_nxt;
  logic [5:0]               theta, theta_nxt, theta_chk;
  logic                     pending, pend_nxt;
  logic                     done_q, miss_l_q, miss_r_q;
  logic                     done_nxt, miss_l_nxt, miss_r_nxt;

  logic signed [7:0]        sin_q, cos_q;
  logic signed [10:0]       dx, dy;
  logic signed [POS_W-1:0]  dx_ext, dy_ext;
  logic                     x_under, x_over, y_under, y_over;

  localparam logic signed [10:0] SPEED_S = 11'(SPEED);

  ball_motion_trig u_trig (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_LOOKUP),
    .theta_i (theta),
    .sin_o   (sin_q),
    .cos_o   (cos_q)
  );

  // Step in 1/128 px; trig magnitude 128 with SPEED 2 gives exactly 2.0 px.
  assign dx     = $signed({{3{cos_q[7]}}, cos_q}) * SPEED_S;
  assign dy     = $signed({{3{sin_q[7]}}, sin_q}) * SPEED_S;
  assign dx_ext = $signed({{(POS_W-11){dx[10]}}, dx});
  assign dy_ext = $signed({{(POS_W-11){dy[10]}}, dy});

  // Evaluated in CHECK on the positions written during MOVE.
  assign x_under = x_pos[POS_W-1];
  assign x_over  = !x_under && (x_pos >= X_LIMIT);
  assign y_under = y_pos[POS_W-1];
  assign y_over  = !y_under && (y_pos >= Y_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_PARKED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_pos;
    y_nxt      = y_pos;
    theta_nxt  = theta;
    theta_chk  = theta;
    pend_nxt   = pending;
    done_nxt   = 1'b0;
    miss_l_nxt = 1'b0;
    miss_r_nxt = 1'b0;
    if (bus.serve_i) begin
      // Serve overrides everything, including a step in flight.
      x_nxt     = X_CENTRE;
      y_nxt     = Y_CENTRE;
      theta_nxt = bus.theta_serve_i;
      pend_nxt  = 1'b0;
      state_nxt = ST_IDLE;
    end else begin
      if (bus.bounce_x_i && state != ST_PARKED) pend_nxt = 1'b1;
      unique case (state)
        ST_PARKED: ;
        ST_IDLE:   if (bus.frame_i) state_nxt = ST_LOOKUP;
        ST_LOOKUP: state_nxt = ST_MOVE;
        ST_MOVE: begin
          x_nxt     = x_pos + dx_ext;
          y_nxt     = y_pos + dy_ext;
          state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
          if (x_under || x_over) begin
            // Miss wins over any wall or paddle reflection.
            miss_l_nxt = x_under;
            miss_r_nxt = x_over;
            x_nxt      = X_CENTRE;
            y_nxt      = Y_CENTRE;
            pend_nxt   = 1'b0;
            state_nxt  = ST_PARKED;
          end else begin
            if (y_under) begin
              y_nxt     = '0;
              theta_chk = reflect_wall(theta_chk);
            end else if (y_over) begin
              y_nxt     = Y_CLAMP;
              theta_chk = reflect_wall(theta_chk);
            end
            // pend_nxt already includes a bounce arriving in this cycle.
            if (pend_nxt) begin
              theta_chk = reflect_paddle(theta_chk);
              pend_nxt  = 1'b0;
            end
            theta_nxt = theta_chk;
          end
        end
        default: state_nxt = ST_PARKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos    <= X_CENTRE;
      y_pos    <= Y_CENTRE;
      theta    <= '0;
      pending  <= 1'b0;
      done_q   <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      x_pos    <= x_nxt;
      y_pos    <= y_nxt;
      theta    <= theta_nxt;
      pending  <= pend_nxt;
      done_q   <= done_nxt;
      miss_l_q <= miss_l_nxt;
      miss_r_q <= miss_r_nxt;
    end
  end

  // Integer parts; the position is negative only transiently before CHECK.
  assign bus.ball_x_o     = x_pos[POS_W-1] ? '0 : x_pos[FRAC_W +: COORD_W];
  assign bus.ball_y_o     = y_pos[POS_W-1] ? '0 : y_pos[FRAC_W +: COORD_W];
  assign bus.theta_o      = theta;
  assign bus.busy_o       = (state == ST_LOOKUP) || (state == ST_MOVE) || (state == ST_CHECK);
  assign bus.done_o       = done_q;
  assign bus.miss_left_o  = miss_l_q;
  assign bus.miss_right_o = miss_r_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;
  import ball_motion_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  ball_motion_if bus();

  ball_motion dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in 1/128 px units; a step is modelled as a whole once it completes.
  localparam real PI = 3.14159265358979;

  bit m_parked, m_pend, m_done, m_ml, m_mr;
  int m_cnt, m_x, m_y, m_theta;

  function automatic int round_clamp(input real r);
    int v;
    v = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int ref_sin(input int t);
    return round_clamp(128.0 * $sin(2.0 * PI * t / 64.0));
  endfunction

  function automatic int ref_cos(input int t);
    return round_clamp(128.0 * $cos(2.0 * PI * t / 64.0));
  endfunction

  task automatic model_reset();
    m_parked = 1; m_pend = 0; m_cnt = 0;
    m_x = XC * 128; m_y = YC * 128; m_theta = 0;
    m_done = 0; m_ml = 0; m_mr = 0;
  endtask

  task automatic model_step();
    int nx, ny;
    nx = m_x + ref_cos(m_theta) * SPEED;
    ny = m_y + ref_sin(m_theta) * SPEED;
    m_done = 1;
    if (nx < 0 || nx / 128 > X_MAX) begin
      m_ml = (nx < 0);
      m_mr = (nx >= 0);
      m_x = XC * 128; m_y = YC * 128;
      m_pend = 0; m_parked = 1;
    end else begin
      m_x = nx;
      if (ny < 0) begin
        m_y = 0; m_theta = (64 - m_theta) % 64;
      end else if (ny / 128 > Y_MAX) begin
        m_y = Y_MAX * 128; m_theta = (64 - m_theta) % 64;
      end else begin
        m_y = ny;
      end
      if (m_pend) begin
        m_theta = (96 - m_theta) % 64;
        m_pend = 0;
      end
    end
  endtask

  task automatic model_edge(input bit r, input bit f, input bit s, input int ts, input bit b);
    m_done = 0; m_ml = 0; m_mr = 0;
    if (r) begin
      model_reset();
    end else if (s) begin
      m_parked = 0; m_cnt = 0; m_pend = 0;
      m_x = XC * 128; m_y = YC * 128; m_theta = ts;
    end else if (!m_parked) begin
      if (b) m_pend = 1;
      if (m_cnt == 0) begin
        if (f) m_cnt = 3;
      end else begin
        m_cnt--;
        if (m_cnt == 0) model_step();
      end
    end
  endtask

  task automatic model_compare();
    check("m_busy",   int'(bus.busy_o),       int'(m_cnt != 0));
    check("m_done",   int'(bus.done_o),       int'(m_done));
    check("m_missl",  int'(bus.miss_left_o),  int'(m_ml));
    check("m_missr",  int'(bus.miss_right_o), int'(m_mr));
    check("m_theta",  int'(bus.theta_o),      m_theta);
    check("m_parked", int'(dbg_state == ST_PARKED), int'(m_parked));
    if (m_cnt == 0) begin
      check("m_x", int'(bus.ball_x_o), m_x / 128);
      check("m_y", int'(bus.ball_y_o), m_y / 128);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit r, input bit f, input bit s, input int ts, input bit b);
    @(negedge clk);
    rst               = r;
    bus.frame_i       = f;
    bus.serve_i       = s;
    bus.theta_serve_i = 6'(ts);
    bus.bounce_x_i    = b;
    @(posedge clk);
    model_edge(r, f, s, ts, b);
    #1;
    model_compare();
  endtask

  // One frame request, then wait (bounded) for done_o; lat = -1 if none.
  task automatic run_step(output int lat);
    tick(0, 1, 0, 0, 0);
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      tick(0, 0, 0, 0, 0);
      if (bus.done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; bit f; bit s; int ts; bit b;
    int x; int y; int th; bit busy; bit done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit f, input bit s, input int ts, input bit b,
                     input int x, input int y, input int th, input bit busy, input bit done);
    vec_t v;
    v.r = r; v.f = f; v.s = s; v.ts = ts; v.b = b;
    v.x = x; v.y = y; v.th = th; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endtask

  initial begin
    int lat, dones;
    bit r, f, s, b;

    rst = 1'b1;
    bus.frame_i = 1'b0; bus.serve_i = 1'b0; bus.theta_serve_i = '0; bus.bounce_x_i = 1'b0;
    model_reset();

    // Serve theta=0, two frames, then a paddle bounce and two more frames.
    add(1,0,0,0,0, 316,236, 0,0,0);
    add(0,0,1,0,0, 316,236, 0,0,0);
    add(0,1,0,0,0, 316,236, 0,1,0);
    add(0,0,0,0,0, 316,236, 0,1,0);
    add(0,0,0,0,0, 317,236, 0,1,0);
    add(0,0,0,0,0, 317,236, 0,0,1);
    add(0,1,0,0,0, 317,236, 0,1,0);
    add(0,0,0,0,0, 317,236, 0,1,0);
    add(0,0,0,0,0, 319,236, 0,1,0);
    add(0,0,0,0,0, 319,236, 0,0,1);
    add(0,0,0,0,1, 319,236, 0,0,0);
    add(0,1,0,0,0, 319,236, 0,1,0);
    add(0,0,0,0,0, 319,236, 0,1,0);
    add(0,0,0,0,0, 321,236, 0,1,0);
    add(0,0,0,0,0, 321,236,32,0,1);
    add(0,1,0,0,0, 321,236,32,1,0);
    add(0,0,0,0,0, 321,236,32,1,0);
    add(0,0,0,0,0, 319,236,32,1,0);
    add(0,0,0,0,0, 319,236,32,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].ts, tbl[i].b);
      check($sformatf("tbl%0d_x", i),    int'(bus.ball_x_o), tbl[i].x);
      check($sformatf("tbl%0d_y", i),    int'(bus.ball_y_o), tbl[i].y);
      check($sformatf("tbl%0d_th", i),   int'(bus.theta_o),  tbl[i].th);
      check($sformatf("tbl%0d_busy", i), int'(bus.busy_o),   int'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i), int'(bus.done_o),   int'(tbl[i].done));
    end

    // Heading 48 climbs 2 px/frame into the top wall and reflects to 16.
    tick(0, 0, 1, 48, 0);
    for (int i = 1; i <= 119; i++) begin
      run_step(lat);
      check("t2_lat", lat, 3);
      check("t2_y", int'(bus.ball_y_o), (i <= 118) ? 236 - 2 * i : 0);
    end
    check("t2_theta", int'(bus.theta_o), 16);
    check("t2_x", int'(bus.ball_x_o), 316);

    // Heading 32 runs left to x=0, then misses and parks.
    tick(0, 0, 1, 32, 0);
    for (int i = 1; i <= 158; i++) begin
      run_step(lat);
      check("t3_x", int'(bus.ball_x_o), 316 - 2 * i);
    end
    run_step(lat);
    check("t3_lat", lat, 3);
    check("t3_missl", int'(bus.miss_left_o), 1);
    check("t3_x_centre", int'(bus.ball_x_o), 316);
    check("t3_parked", int'(dbg_state == ST_PARKED), 1);
    run_step(lat);
    check("t3_ignored", lat, -1);

    // Repeated frames while busy yield exactly one done.
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0, 0);
      dones += int'(bus.done_o);
    end
    check("t5_one_done", dones, 1);
    check("t5_x", int'(bus.ball_x_o), 317);

    // Serve in MOVE aborts the step.
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t5_in_move", int'(dbg_state == ST_MOVE), 1);
    tick(0, 0, 1, 7, 0);
    check("t5_serve_x", int'(bus.ball_x_o), 316);
    check("t5_serve_th", int'(bus.theta_o), 7);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0);
      dones += int'(bus.done_o);
    end
    check("t5_no_done", dones, 0);

    // Reset during CHECK.
    tick(0, 0, 1, 5, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t6_in_check", int'(dbg_state == ST_CHECK), 1);
    tick(1, 0, 0, 0, 0);
    check("t6_parked", int'(dbg_state == ST_PARKED), 1);
    check("t6_x", int'(bus.ball_x_o), 316);
    check("t6_y", int'(bus.ball_y_o), 236);
    check("t6_theta", int'(bus.theta_o), 0);
    check("t6_done", int'(bus.done_o), 0);
    check("t6_miss", int'(bus.miss_left_o | bus.miss_right_o), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 699) == 0);
      s = m_parked ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 249) == 0);
      f = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 29) == 0);
      tick(r, f, s, int'($urandom_range(0, 63)), b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
